// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides clk to the pixel rate, walks col/row over the frame, and decodes syncs, the visible window and strobes.
// Every output is decoded from registered state only; dropping en stops the block and rewinds it to pixel (0,0), div 0.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [10:0] row,
  output logic [10:0] col,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_output_valid,
  output logic        pix_tick,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Widths hold the full total so that sync-end bounds never wrap
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  state_t        state;
  logic [DW-1:0] div_q;
  logic [HW-1:0] col_q;
  logic [VW-1:0] row_q;
  logic          running;
  logic          tick;

  assign running = (state == RUNNING);
  assign tick    = running && (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STOPPED;
      div_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      case (state)
        STOPPED: begin
          div_q <= '0;
          col_q <= '0;
          row_q <= '0;
          if (en) state <= RUNNING;
        end
        RUNNING: begin
          if (!en) begin
            state <= STOPPED;
            div_q <= '0;
            col_q <= '0;
            row_q <= '0;
          end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (div_q == DIV_LAST) begin
              if (col_q == H_LAST) begin
                col_q <= '0;
                row_q <= (row_q == V_LAST) ? '0 : row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state <= STOPPED;
          div_q <= '0;
          col_q <= '0;
          row_q <= '0;
        end
      endcase
    end
  end

  // Counters are already zero while stopped, so row/col need no gating
  assign row              = 11'(row_q);
  assign col              = 11'(col_q);
  assign pix_tick         = tick;
  assign hsync            = ~(running && (col_q >= HS_START) && (col_q < HS_END));
  assign vsync            = ~(running && (row_q >= VS_START) && (row_q < VS_END));
  assign vga_output_valid = running && (col_q < H_VIS) && (row_q < V_VIS);
  assign line_start       = running && (div_q == '0) && (col_q == '0);
  assign frame_start      = line_start && (row_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, small CLK_DIV=3, small CLK_DIV=1) checked cycle by cycle against a closed-form model.
module tb_vga_timing_gen;

  localparam int HV[3] = '{640, 16, 16};
  localparam int HF[3] = '{16, 2, 2};
  localparam int HS[3] = '{96, 3, 3};
  localparam int HB[3] = '{48, 4, 4};
  localparam int VV[3] = '{480, 12, 12};
  localparam int VF[3] = '{10, 2, 2};
  localparam int VS[3] = '{2, 2, 2};
  localparam int VB[3] = '{33, 3, 3};
  localparam int DV[3] = '{2, 3, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [10:0] row [3];
  logic [10:0] col [3];
  logic        hs [3];
  logic        vs [3];
  logic        vld [3];
  logic        pt [3];
  logic        ls [3];
  logic        fs [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit run [3];
  int n [3];
  logic [27:0] exp_q [$];

  int last_ls [3];
  int last_fs [3];
  int hs_fall [3];
  int vs_fall [3];
  int vcnt [3];
  logic prev_hs [3];
  logic prev_vs [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vga_timing_gen #(
      .H_VISIBLE(HV[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_VISIBLE(VV[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .CLK_DIV(DV[g])
    ) dut (
      .clk(clk), .reset(reset), .en(en),
      .row(row[g]), .col(col[g]), .hsync(hs[g]), .vsync(vs[g]),
      .vga_output_valid(vld[g]), .pix_tick(pt[g]),
      .line_start(ls[g]), .frame_start(fs[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected outputs from the run length since the first RUNNING clk
  function automatic logic [27:0] expv(input int k, input bit r, input int nn);
    int ht, vt, p, d, c, rw;
    logic h, v, vl, tk, l, f;
    if (!r) return {11'd0, 11'd0, 1'b1, 1'b1, 4'b0000};
    ht = HV[k] + HF[k] + HS[k] + HB[k];
    vt = VV[k] + VF[k] + VS[k] + VB[k];
    d  = nn % DV[k];
    p  = nn / DV[k];
    c  = p % ht;
    rw = (p / ht) % vt;
    h  = !(c >= HV[k] + HF[k] && c < HV[k] + HF[k] + HS[k]);
    v  = !(rw >= VV[k] + VF[k] && rw < VV[k] + VF[k] + VS[k]);
    vl = (c < HV[k]) && (rw < VV[k]);
    tk = (d == DV[k] - 1);
    l  = (d == 0) && (c == 0);
    f  = l && (rw == 0);
    return {11'(rw), 11'(c), h, v, vl, tk, l, f};
  endfunction

  function automatic logic [27:0] obs(input int k);
    return {row[k], col[k], hs[k], vs[k], vld[k], pt[k], ls[k], fs[k]};
  endfunction

  task automatic push_all();
    for (int k = 0; k < 3; k++) exp_q.push_back(expv(k, run[k], n[k]));
  endtask

  task automatic pop_all();
    for (int k = 0; k < 3; k++) begin
      logic [27:0] e;
      e = exp_q.pop_front();
      check($sformatf("outputs_dut%0d", k), 32'(obs(k)), 32'(e));
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < 3; k++) begin
      int ht, vt;
      ht = HV[k] + HF[k] + HS[k] + HB[k];
      vt = VV[k] + VF[k] + VS[k] + VB[k];
      if (!run[k]) begin
        last_ls[k] = -1; last_fs[k] = -1; hs_fall[k] = -1; vs_fall[k] = -1;
        vcnt[k] = 0; prev_hs[k] = 1'b1; prev_vs[k] = 1'b1;
      end else begin
        if (ls[k]) begin
          if (last_ls[k] >= 0) check($sformatf("line_period%0d", k), 32'(cyc - last_ls[k]), 32'(ht * DV[k]));
          last_ls[k] = cyc;
        end
        if (fs[k]) begin
          if (last_fs[k] >= 0) check($sformatf("frame_period%0d", k), 32'(cyc - last_fs[k]), 32'(ht * vt * DV[k]));
          last_fs[k] = cyc;
        end
        if (prev_hs[k] && !hs[k]) begin
          if (last_ls[k] >= 0) check($sformatf("hsync_fall%0d", k), 32'(cyc - last_ls[k]), 32'((HV[k] + HF[k]) * DV[k]));
          hs_fall[k] = cyc;
        end
        if (!prev_hs[k] && hs[k] && hs_fall[k] >= 0)
          check($sformatf("hsync_width%0d", k), 32'(cyc - hs_fall[k]), 32'(HS[k] * DV[k]));
        if (prev_vs[k] && !vs[k]) vs_fall[k] = cyc;
        if (!prev_vs[k] && vs[k] && vs_fall[k] >= 0)
          check($sformatf("vsync_width%0d", k), 32'(cyc - vs_fall[k]), 32'(VS[k] * ht * DV[k]));
        if (vld[k]) vcnt[k]++;
        else if (vcnt[k] > 0) begin
          check($sformatf("valid_len%0d", k), 32'(vcnt[k]), 32'(HV[k] * DV[k]));
          vcnt[k] = 0;
        end
        prev_hs[k] = hs[k];
        prev_vs[k] = vs[k];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!reset) run[k] = 1'b0;
      else if (!run[k]) begin
        if (en) begin run[k] = 1'b1; n[k] = 0; end
      end else if (!en) run[k] = 1'b0;
      else n[k]++;
    end
    push_all();
    @(negedge clk);
    cyc++;
    pop_all();
    monitor();
  endtask

  initial begin
    int guard;
    for (int k = 0; k < 3; k++) begin
      run[k] = 1'b0; n[k] = 0;
    end
    monitor();
    reset = 1'b0;
    en    = 1'b0;
    #1;
    push_all();
    pop_all();
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    en = 1'b1;
    guard = 0;
    while (!(run[0] && n[0] == 16600) && guard < 20000) begin
      step();
      guard++;
    end
    check("pos_before_drop", 32'({row[0], col[0]}), 32'({11'd10, 11'd300}));

    en = 1'b0;
    step();
    check("stopped_col", 32'(col[0]), 32'd0);
    en = 1'b1;
    step();
    check("restore_frame_start", 32'(fs[0]), 32'd1);

    guard = 0;
    while (!(run[1] && n[1] == 555) && guard < 2000) begin
      step();
      guard++;
    end
    check("pos_before_reset", 32'({row[1], col[1]}), 32'({11'd7, 11'd10}));

    // Asynchronous assertion between clock edges
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) run[k] = 1'b0;
    push_all();
    pop_all();
    check("async_hsync", 32'(hs[0]), 32'd1);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("restart_origin", 32'({row[1], col[1], fs[1]}), 32'({11'd0, 11'd0, 1'b1}));
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch in lines.
REQ-009 SHALL have parameter CLK_DIV, default 2: clk cycles per pixel, legal range 1..16.
REQ-010 SHALL have port clk, input, 1 bit: the single clock for the block; all logic is on its rising edge.
REQ-011 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-012 SHALL have port en, input, 1 bit: run enable for the timing counters.
REQ-013 SHALL have port row, output, 11 bits: current line number, 0..H/V total-1 (vertical).
REQ-014 SHALL have port col, output, 11 bits: current pixel number within the line.
REQ-015 SHALL have port hsync, output, 1 bit: horizontal sync, active low.
REQ-016 SHALL have port vsync, output, 1 bit: vertical sync, active low.
REQ-017 SHALL have port vga_output_valid, output, 1 bit: the current pixel lies in the visible region and the block is running.
REQ-018 SHALL have port pix_tick, output, 1 bit: one-clk strobe marking the last clk of each pixel period.
REQ-019 SHALL have port line_start, output, 1 bit: one-clk pulse when col wraps to 0.
REQ-020 SHALL have port frame_start, output, 1 bit: one-clk pulse when row and col both wrap to 0.

Function
REQ-021 SHALL define H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-022 SHALL keep a divider counter div, 0..CLK_DIV-1, that increments each clk while running and wraps to 0; pix_tick = running && div==CLK_DIV-1; with CLK_DIV=1, pix_tick = running.
REQ-023 SHALL advance col by 1 on each clk where pix_tick=1; col==H_TOTAL-1 wraps to 0 and the same edge advances row.
REQ-024 SHALL wrap row from V_TOTAL-1 to 0 only on the edge where col also wraps.
REQ-025 SHALL have a 2-state FSM, STOPPED and RUNNING: STOPPED->RUNNING on a clk edge with en=1; RUNNING->STOPPED on a clk edge with en=0.
REQ-026 On entry to STOPPED, SHALL clear div, col and row to 0 on the same edge, so the next run always starts at pixel (0,0), div 0.
REQ-027 SHALL decode all outputs combinationally from registered state only (no combinational path from en to any output).
REQ-028 SHALL drive hsync=0 iff RUNNING and H_VISIBLE+H_FP <= col < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise 1.
REQ-029 SHALL drive vsync=0 iff RUNNING and V_VISIBLE+V_FP <= row < V_VISIBLE+V_FP+V_SYNC (490..491); otherwise 1.
REQ-030 SHALL drive vga_output_valid=1 iff RUNNING, col<H_VISIBLE and row<V_VISIBLE.
REQ-031 SHALL drive line_start=1 iff RUNNING, div==0 and col==0, for exactly one clk per line.
REQ-032 SHALL drive frame_start=1 iff line_start=1 and row==0.
REQ-033 In STOPPED, SHALL drive row=col=0, hsync=vsync=1, and pix_tick, line_start, frame_start and vga_output_valid all 0.
REQ-034 SHALL make counter widths sufficient for the parameters without overflow; comparisons are unsigned.

Reset
REQ-035 SHALL, while reset=0, asynchronously force STOPPED and div=col=row=0, giving the outputs of REQ-033.
REQ-036 SHALL, after reset deasserts, enter RUNNING on the first rising clk edge with en=1; at that point row=col=0 and vga_output_valid=1.
REQ-037 SHALL, when reset asserts mid-frame, return the outputs to REQ-033 values immediately, without waiting for a clk edge.

Verification
REQ-038 Default parameters, reset released and en=1 held -> first RUNNING clk is T0; hsync falls at T0+1312 clk; hsync stays low 192 clk; line_start repeats every 1600 clk.
REQ-039 Same setup -> vga_output_valid high for 1280 clk then low for 320 clk per line; it stays low for all clks with row 480..524.
REQ-040 Same setup -> vsync low during row 490..491 (3200 clk); frame_start pulses at T0 and at T0+840000, and nowhere between.
REQ-041 en dropped at col=300, row=10, then restored -> next clk outputs match REQ-033; on restore, RUNNING resumes with row=col=0 and frame_start=1.
REQ-042 reset asserted asynchronously at row=200, col=500 -> outputs match REQ-033 before the next clk edge; after release with en=1, counting restarts from (0,0).
REQ-043 CLK_DIV=1 -> pix_tick constantly high while RUNNING, line period 800 clk, frame period 420000 clk.
